// File: rtl/approx_adder_err_sweeper_pkg.sv
// Shared types and width helpers for the approximate-adder error sweeper.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic int err_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int sum_w(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic int lat_w(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

  // Operands split evenly and the sum needs exactly one carry bit.
  function automatic bit widths_ok(input int n_in, input int n_out);
    return (n_in >= 2) && (n_in % 2 == 0) && (n_out == n_in / 2 + 1);
  endfunction

endpackage

// File: rtl/approx_adder_err_sweeper_if.sv
// Stimulus/response bus between the sweeper and the adder under evaluation.
interface approx_adder_err_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;

  modport master (output dut_in, input dut_out);
  modport slave  (input dut_in, output dut_out);
endinterface

// File: rtl/approx_adder_err_sweeper_absdiff.sv
// Splits a stimulus vector into A/B, forms the exact sum and the absolute
// difference against the observed response.
module approx_err_absdiff #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic [N_IN-1:0]  vec_i,
  input  logic [N_OUT-1:0] resp_i,
  output logic [N_OUT-1:0] abs_err_o
);
  localparam int HALF = N_IN / 2;

  logic [HALF-1:0]  op_a;
  logic [HALF-1:0]  op_b;
  logic [N_OUT-1:0] exact;

  assign op_a      = vec_i[HALF-1:0];
  assign op_b      = vec_i[N_IN-1:HALF];
  assign exact     = N_OUT'(op_a) + N_OUT'(op_b);
  assign abs_err_o = (resp_i >= exact) ? (resp_i - exact) : (exact - resp_i);
endmodule

// File: rtl/approx_adder_err_sweeper.sv
// Exhaustive sweep of an approximate adder: drives every vector, samples the
// response after the DUT latency and accumulates error statistics.
module approx_adder_err_sweeper
  import approx_eval_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 3,
  parameter int ET      = 5,
  parameter int DUT_LAT = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  approx_adder_err_sweeper_if.master      dut_if,
  output logic                            busy,
  output logic                            done,
  output logic                            results_valid,
  output logic                            pass,
  output logic [N_OUT-1:0]                max_err,
  output logic [err_cnt_w(N_IN)-1:0]      err_count,
  output logic [sum_w(N_IN, N_OUT)-1:0]   sum_abs_err,
  output logic [N_IN-1:0]                 first_fail_vec,
  output logic                            fail_valid
);
  localparam int ERR_W  = err_cnt_w(N_IN);
  localparam int SUM_W  = sum_w(N_IN, N_OUT);
  localparam int LAT_W  = lat_w(DUT_LAT);
  localparam int ET_MAX = (1 << N_OUT) - 1;
  localparam logic [N_OUT-1:0] ET_V  = (ET >= ET_MAX) ? N_OUT'(ET_MAX) : N_OUT'(ET);
  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(DUT_LAT);

  generate
    if (!widths_ok(N_IN, N_OUT)) begin : g_bad_cfg
      $error("approx_adder_err_sweeper: N_IN must be even and N_OUT must equal N_IN/2+1");
    end
  endgenerate

  state_e             state_q;
  logic [N_IN-1:0]    vec_q;
  logic [LAT_W-1:0]   wait_q;
  logic [N_OUT-1:0]   resp_q;
  logic               busy_q, done_q, valid_q, pass_q, fail_valid_q;
  logic [N_OUT-1:0]   max_err_q, max_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [N_IN-1:0]    first_fail_q;
  logic [N_OUT-1:0]   abs_err;
  logic               over_et;

  approx_err_absdiff #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_absdiff (
    .vec_i     (vec_q),
    .resp_i    (resp_q),
    .abs_err_o (abs_err)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    max_err_d   = max_err_q;
    err_count_d = err_count_q;
    sum_d       = sum_q + SUM_W'(abs_err);
    over_et     = abs_err > ET_V;
    if (abs_err > max_err_q) max_err_d = abs_err;
    if (abs_err != '0)       err_count_d = err_count_q + ERR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      wait_q       <= '0;
      resp_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      pass_q       <= 1'b0;
      max_err_q    <= '0;
      err_count_q  <= '0;
      sum_q        <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      // The response is registered, so CHECK sees the value present DUT_LAT+1 edges after the load.
      resp_q <= dut_if.dut_out;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q        <= '0;
            wait_q       <= LAT_V;
            busy_q       <= 1'b1;
            valid_q      <= 1'b0;
            pass_q       <= 1'b0;
            max_err_q    <= '0;
            err_count_q  <= '0;
            sum_q        <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (wait_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            wait_q <= wait_q - LAT_W'(1);
          end
        end
        ST_CHECK: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            max_err_q   <= max_err_d;
            err_count_q <= err_count_d;
            sum_q       <= sum_d;
            if (over_et && !fail_valid_q) begin
              first_fail_q <= vec_q;
              fail_valid_q <= 1'b1;
            end
            if (&vec_q) begin
              // Outputs are registered on entry so they coincide with the DONE cycle.
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              pass_q  <= (max_err_d <= ET_V);
              state_q <= ST_DONE;
            end else begin
              vec_q   <= vec_q + N_IN'(1);
              wait_q  <= LAT_V;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_if.dut_in  = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign results_valid  = valid_q;
  assign pass           = pass_q;
  assign max_err        = max_err_q;
  assign err_count      = err_count_q;
  assign sum_abs_err    = sum_q;
  assign first_fail_vec = first_fail_q;
  assign fail_valid     = fail_valid_q;

endmodule
